inst_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory interface: owns the program counter,

---
 rtl/inst_fetch_unit.sv | 103 ++++++++++
 tb/tb_inst_fetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the pc, captures inst from a combinational
// instruction memory and queues {pc, inst} toward decode. Optional perf counters: FETCH_PERF_EN.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [1:0]  fill_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [31:0]      q_pc   [QDEPTH];
  logic [31:0]      q_inst [QDEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             push;
  logic             pop;
  logic             unused_rpc_bits;

  // Output handshake: a head entry transfers on a cycle where out_valid and
  // out_ready are both high and redirect is low; redirect discards the head.
  assign full      = (count == CNT_W'(QDEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = ~redirect & (~full | pop);

  assign out_inst  = out_valid ? q_inst[rd_ptr] : NOP_INST;
  assign out_pc    = out_valid ? q_pc[rd_ptr]   : 32'h0;

  assign unused_rpc_bits = ^redirect_pc[1:0];

  always_comb begin
    fill_state = ST_PARTIAL;
    if (count == '0) fill_state = ST_EMPTY;
    else if (full)   fill_state = ST_FULL;
  end

  // Storage has no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= pc;
      q_inst[wr_ptr] <= inst;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= {RESET_PC[31:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      pc     <= {redirect_pc[31:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        pc     <= pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= 32'h0;
      flush_count <= 32'h0;
    end else begin
      if (push)     fetch_count <= fetch_count + 32'd1;
      if (redirect) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: reset, streaming, backpressure, redirect,
// full+pop+redirect, back-to-back redirect, pc wrap and optional perf counters.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [1:0]  fill_state;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  int          n_checks = 0;
  int          n_bad    = 0;
  logic        sb_on    = 1'b0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .inst        (inst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .fill_state  (fill_state)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count (fetch_count),
    .flush_count (flush_count)
`endif
  );

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  assign inst = mem_word(pc);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted head pc must match the next expected one
  always @(posedge clk) begin
    if (sb_on && rst && out_valid && out_ready && !redirect) begin
      if (exp_q.size() > 0) begin
        check("sb_pop_pc", out_pc, exp_q.pop_front());
      end else begin
        n_checks++;
        n_bad++;
        $display("FAIL sb_unexpected_pop: got pc %h expected no transfer", out_pc);
      end
    end
  end

  initial begin
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    #1 rst = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_inst", out_inst, 32'h0000_0013);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_state", fill_state, 2'd0);

    // streaming with out_ready held high
    out_ready = 1'b1;
    rst       = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("stream_valid", out_valid, 1'b1);
      check("stream_pc", out_pc, 32'(4 * k));
      check("stream_inst", out_inst, mem_word(32'(4 * k)));
    end
    check("stream_state", fill_state, 2'd1);
    check("stream_fetch_pc", pc, 32'h18);

    // asynchronous reset between clock edges
    #2 rst = 1'b0;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_valid", out_valid, 1'b0);
    check("arst_inst", out_inst, 32'h0000_0013);
    check("arst_out_pc", out_pc, 32'h0);

    // backpressure: fill, hold, then drain without gap or drop
    @(negedge clk);
    out_ready = 1'b0;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    sb_on = 1'b1;
    rst   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("bp_hold_out_pc", out_pc, 32'h0);
    end
    check("bp_hold_pc", pc, 32'h10);
    check("bp_full_state", fill_state, 2'd2);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("bp_drain_pc", out_pc, 32'(4 * k));
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_sb_left", exp_q.size(), 0);
    check("bp_next_head", out_pc, 32'h14);
    check("bp_full_again", fill_state, 2'd2);

    // redirect while head is 0x08
    sb_on = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    exp_q     = '{32'h0, 32'h4, 32'h40};
    sb_on     = 1'b1;
    out_ready = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    check("rd_head0", out_pc, 32'h0);
    @(negedge clk);
    check("rd_head4", out_pc, 32'h4);
    @(negedge clk);
    check("rd_head8", out_pc, 32'h8);
    redirect    = 1'b1;
    redirect_pc = 32'h43;
    @(negedge clk);
    redirect = 1'b0;
    check("rd_valid_drop", out_valid, 1'b0);
    check("rd_pc", pc, 32'h40);
    check("rd_state", fill_state, 2'd0);
    check("rd_out_inst_nop", out_inst, 32'h0000_0013);
    @(negedge clk);
    check("rd_target_valid", out_valid, 1'b1);
    check("rd_target_pc", out_pc, 32'h40);
    check("rd_target_inst", out_inst, mem_word(32'h40));
    @(negedge clk);
    out_ready = 1'b0;
    check("rd_sb_left", exp_q.size(), 0);
    check("rd_after_head", out_pc, 32'h44);

    // full + pop + redirect in the same cycle
    sb_on = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("fpr_full", fill_state, 2'd2);
    check("fpr_pc_hold", pc, 32'h10);
    out_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect  = 1'b0;
    out_ready = 1'b0;
    check("fpr_valid", out_valid, 1'b0);
    check("fpr_state", fill_state, 2'd0);
    check("fpr_pc", pc, 32'h100);
    @(negedge clk);
    check("fpr_head", out_pc, 32'h100);
    repeat (4) @(negedge clk);
    check("fpr_refill_pc", pc, 32'h110);
    check("fpr_refill_state", fill_state, 2'd2);
    check("fpr_refill_head", out_pc, 32'h100);

    // back-to-back redirects: last one wins
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    check("b2b_valid0", out_valid, 1'b0);
    check("b2b_pc0", pc, 32'h200);
    redirect_pc = 32'h303;
    @(negedge clk);
    redirect = 1'b0;
    check("b2b_valid1", out_valid, 1'b0);
    check("b2b_pc1", pc, 32'h300);
    @(negedge clk);
    check("b2b_head", out_pc, 32'h300);

    // pc wrap from FFFF_FFFC, low target bits ignored
    out_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect = 1'b0;
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_head_top", out_pc, 32'hFFFF_FFFC);
    check("wrap_pc_zero", pc, 32'h0);
    @(negedge clk);
    check("wrap_head_zero", out_pc, 32'h0);
    check("wrap_inst_zero", out_inst, mem_word(32'h0));

`ifdef FETCH_PERF_EN
    // perf counters: 10 pushes then 2 redirect cycles
    rst = 1'b0;
    @(negedge clk);
    check("perf_rst_fetch", fetch_count, 32'h0);
    check("perf_rst_flush", flush_count, 32'h0);
    out_ready = 1'b1;
    rst       = 1'b1;
    repeat (10) @(negedge clk);
    check("perf_fetch10", fetch_count, 32'd10);
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    repeat (2) @(negedge clk);
    redirect = 1'b0;
    check("perf_flush2", flush_count, 32'd2);
    check("perf_fetch_hold", fetch_count, 32'd10);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
